// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: debounced pushbutton walks switch values into a registered operand set for the adder
module operand_entry_fsm #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_N,
  input  logic [4:0] SW,
  output logic [3:0] OP_A,
  output logic [3:0] OP_B,
  output logic       OP_SUB,
  output logic       OP_VALID,
  output logic [1:0] STATE_LED
);
  typedef enum logic [1:0] {
    S_LOAD_A = 2'b00,
    S_LOAD_B = 2'b01,
    S_READY  = 2'b10,
    S_BAD    = 2'b11
  } state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic             key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic             deb_q, deb_d, press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ, at_max;
  state_t           state_q, state_d;
  logic [3:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_sub_q, op_sub_d, op_valid_q, op_valid_d;
  // synchronize the raw key, debounce it, and flag only the debounced press (1->0)
  always_comb begin
    key_s1_d = KEY_N;
    key_s2_d = key_s1_q;
    differ   = key_s2_q != deb_q;
    at_max   = cnt_q == CNT_MAX;
    deb_d    = (differ && at_max) ? key_s2_q : deb_q;
    cnt_d    = (differ && !at_max) ? cnt_q + 1'b1 : '0;
    press_d  = deb_q & ~deb_d;
  end
  // load sequence: A, then B with mode, then a fresh A restarts the pair
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sub_d   = op_sub_q;
    op_valid_d = op_valid_q;
    case (state_q)
      S_LOAD_A: if (press_q) begin
        op_a_d  = SW[3:0];
        state_d = S_LOAD_B;
      end
      S_LOAD_B: if (press_q) begin
        op_b_d     = SW[3:0];
        op_sub_d   = SW[4];
        op_valid_d = 1'b1;
        state_d    = S_READY;
      end
      S_READY: if (press_q) begin
        op_a_d     = SW[3:0];
        op_valid_d = 1'b0;
        state_d    = S_LOAD_B;
      end
      default: begin
        op_valid_d = 1'b0;
        state_d    = S_LOAD_A;
      end
    endcase
  end
  // every piece of state lives here; the key path resets to the released level
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      deb_q      <= 1'b1;
      cnt_q      <= '0;
      press_q    <= 1'b0;
      state_q    <= S_LOAD_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sub_q   <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sub_q   <= op_sub_d;
      op_valid_q <= op_valid_d;
    end
  end
  assign OP_A      = op_a_q;
  assign OP_B      = op_b_q;
  assign OP_SUB    = op_sub_q;
  assign OP_VALID  = op_valid_q;
  assign STATE_LED = state_q;
endmodule

// File: tb/tb_operand_entry_fsm.sv
// tb_operand_entry_fsm: directed checks of the operand load sequence with a short debounce
module tb_operand_entry_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic [4:0] sw = '0;
  logic [3:0] op_a, op_b;
  logic       op_sub, op_valid;
  logic [1:0] state_led;
  int         total = 0;
  int         bad = 0;
  operand_entry_fsm #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .KEY_N(key_n),
    .SW(sw),
    .OP_A(op_a),
    .OP_B(op_b),
    .OP_SUB(op_sub),
    .OP_VALID(op_valid),
    .STATE_LED(state_led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    key_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask
  task automatic press(input logic [4:0] v);
    sw = v;
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
  endtask
  initial begin
    tick(2);
    chk("rst_a", 8'(op_a), 8'h0);
    chk("rst_b", 8'(op_b), 8'h0);
    chk("rst_sub", 8'(op_sub), 8'h0);
    chk("rst_valid", 8'(op_valid), 8'h0);
    chk("rst_state", 8'(state_led), 8'h0);
    rst = 1'b0;
    tick(2);
    press(5'b0_0011);
    chk("t1_a", 8'(op_a), 8'h3);
    chk("t1_state_b", 8'(state_led), 8'h1);
    sw = 5'b1_0101;
    key_n = 1'b0;
    tick(6);
    chk("t1_valid_early", 8'(op_valid), 8'h0);
    tick(1);
    chk("t1_valid_at7", 8'(op_valid), 8'h1);
    chk("t1_a2", 8'(op_a), 8'h3);
    chk("t1_b", 8'(op_b), 8'h5);
    chk("t1_sub", 8'(op_sub), 8'h1);
    chk("t1_state_r", 8'(state_led), 8'h2);
    key_n = 1'b1;
    tick(10);
    press(5'b0_1111);
    chk("t3_a", 8'(op_a), 8'hF);
    chk("t3_valid", 8'(op_valid), 8'h0);
    chk("t3_state", 8'(state_led), 8'h1);
    chk("t3_b", 8'(op_b), 8'h5);
    chk("t3_sub", 8'(op_sub), 8'h1);
    do_reset();
    sw = 5'b0_1001;
    for (int i = 0; i < 10; i++) begin
      key_n = i[0];
      tick(2);
    end
    chk("t2_bounce_state", 8'(state_led), 8'h0);
    key_n = 1'b0;
    tick(20);
    chk("t2_a", 8'(op_a), 8'h9);
    chk("t2_state", 8'(state_led), 8'h1);
    tick(20);
    chk("t2_state_hold", 8'(state_led), 8'h1);
    chk("t2_valid", 8'(op_valid), 8'h0);
    key_n = 1'b1;
    tick(10);
    do_reset();
    key_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sw = 5'((i * 7 + 2) % 32);
      tick(1);
    end
    chk("t4_a", 8'(op_a), 8'hC);
    chk("t4_state", 8'(state_led), 8'h1);
    key_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sw = 5'(i * 5);
      tick(1);
    end
    chk("t4_a_after", 8'(op_a), 8'hC);
    do_reset();
    press(5'b0_0011);
    press(5'b0_0101);
    chk("t5_ready", 8'(state_led), 8'h2);
    key_n = 1'b0;
    tick(4);
    #2 rst = 1'b1;
    #1;
    chk("t5_a", 8'(op_a), 8'h0);
    chk("t5_b", 8'(op_b), 8'h0);
    chk("t5_valid", 8'(op_valid), 8'h0);
    chk("t5_state", 8'(state_led), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    key_n = 1'b1;
    tick(10);
    press(5'b0_0110);
    chk("t5_post_a", 8'(op_a), 8'h6);
    chk("t5_post_state", 8'(state_led), 8'h1);
    sw = 5'b1_1010;
    key_n = 1'b0;
    tick(1);
    key_n = 1'b1;
    tick(10);
    chk("t6_pulse1_state", 8'(state_led), 8'h1);
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(10);
    chk("t6_pulse3_state", 8'(state_led), 8'h1);
    chk("t6_b", 8'(op_b), 8'h0);
    chk("t6_sub", 8'(op_sub), 8'h0);
    chk("t6_a", 8'(op_a), 8'h6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
